// File: rtl/register_view_scheduler_pkg.sv
// Shared constants, view-state encoding and the register-slice helper used by
// the register-heap scheduler and its renderers.
package register_view_scheduler_pkg;

  localparam int DEF_NUM_REGS        = 11;
  localparam int DEF_REG_W           = 16;
  localparam int DEF_PAGE_SIZE       = 4;
  localparam int DEF_DEBOUNCE_CYCLES = 250000;
  localparam int DEF_HILITE_FRAMES   = 30;

  // Highlight counters are 6 bits; page arithmetic carries one spare bit so
  // base+PAGE_SIZE can be compared against NUM_REGS before wrapping.
  localparam int HL_W   = 6;
  localparam int PAGE_W = 5;

  typedef enum logic {
    RUN    = 1'b0,
    FROZEN = 1'b1
  } view_state_e;

  // LSB of register i on the packed bus; reg0 occupies the MSBs, so this is
  // the low end of [(num_regs-i)*reg_w-1 -: reg_w].
  function automatic int reg_lsb(input int i, input int num_regs, input int reg_w);
    return (num_regs - 1 - i) * reg_w;
  endfunction

endpackage

// File: rtl/register_view_scheduler_button_debouncer.sv
// Raw push-button conditioner: 2-flop synchronizer, stable-level counter and a
// single-cycle press pulse on each accepted 0->1 transition.
module register_view_scheduler_button_debouncer #(
  parameter int CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam int CW = $clog2(CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  // NOTE: sequential state is assigned with <= so every flop samples the
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      press <= 1'b0;
      // Any sample that agrees with the accepted level restarts the count.
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(CYCLES - 1)) begin
        level <= sync2;
        cnt   <= '0;
        press <= sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/register_view_scheduler.sv
// Frame-synchronous register-heap view: captures the CPU register bus on
// vsync, pages through it, supports freeze and flags recently changed words.
module register_view_scheduler
  import register_view_scheduler_pkg::*;
#(
  parameter int NUM_REGS        = DEF_NUM_REGS,
  parameter int REG_W           = DEF_REG_W,
  parameter int PAGE_SIZE       = DEF_PAGE_SIZE,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HILITE_FRAMES   = DEF_HILITE_FRAMES
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      vsync_start,
  input  logic [NUM_REGS*REG_W-1:0] registers,
  input  logic                      freeze_btn,
  input  logic                      page_btn,
  output logic [NUM_REGS*REG_W-1:0] snapshot,
  output logic [3:0]                page_base,
  output logic [NUM_REGS-1:0]       changed,
  output logic                      frozen
);

  logic              page_press;
  logic              freeze_press;
  logic              pend_page;
  logic              pend_freeze;
  view_state_e       state;
  logic [HL_W-1:0]   hl_cnt  [NUM_REGS];
  logic [HL_W-1:0]   hl_next [NUM_REGS];
  logic [PAGE_W-1:0] page_sum;
  logic [3:0]        page_wrap;

  register_view_scheduler_button_debouncer #(
    .CYCLES (DEBOUNCE_CYCLES)
  ) u_page_db (
    .clk   (clk),
    .rst   (rst),
    .btn   (page_btn),
    .press (page_press)
  );

  register_view_scheduler_button_debouncer #(
    .CYCLES (DEBOUNCE_CYCLES)
  ) u_freeze_db (
    .clk   (clk),
    .rst   (rst),
    .btn   (freeze_btn),
    .press (freeze_press)
  );

  assign page_sum  = {1'b0, page_base} + PAGE_W'(PAGE_SIZE);
  assign page_wrap = (page_sum >= PAGE_W'(NUM_REGS)) ? 4'd0 : page_sum[3:0];
  assign frozen    = (state == FROZEN);

  // A fresh capture that differs from the shown word reloads its highlight;
  // otherwise every vsync ages the highlight, frozen or not.
  // NOTE: every always_comb target gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      hl_next[i] = hl_cnt[i];
      if (vsync_start) begin
        if (state == RUN &&
            registers[reg_lsb(i, NUM_REGS, REG_W) +: REG_W] !=
            snapshot[reg_lsb(i, NUM_REGS, REG_W) +: REG_W]) begin
          hl_next[i] = HL_W'(HILITE_FRAMES);
        end else if (hl_cnt[i] != '0) begin
          hl_next[i] = hl_cnt[i] - 1'b1;
        end
      end
    end
  end

  // NOTE: the highlight counter array is small and must clear on reset so
  // changed drops immediately, so it sits in the reset branch like any flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snapshot    <= '0;
      page_base   <= '0;
      changed     <= '0;
      state       <= RUN;
      pend_page   <= 1'b0;
      pend_freeze <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) hl_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) hl_cnt[i] <= hl_next[i];
      if (vsync_start) begin
        if (state == RUN) snapshot <= registers;
        for (int i = 0; i < NUM_REGS; i++) changed[i] <= (hl_next[i] != '0);
        if (pend_page) page_base <= page_wrap;
        if (pend_freeze) state <= (state == RUN) ? FROZEN : RUN;
        // A press arriving on the vsync cycle itself waits for the next frame.
        pend_page   <= page_press;
        pend_freeze <= freeze_press;
      end else begin
        if (page_press)   pend_page   <= 1'b1;
        if (freeze_press) pend_freeze <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_register_view_scheduler.sv
// Directed bench for register_view_scheduler: expected frame outputs are queued
// with each vsync pulse and a monitor compares them when the DUT updates.
module tb_register_view_scheduler;

  localparam int N  = 11;
  localparam int W  = 16;
  localparam int BW = N * W;

  typedef struct {
    logic [BW-1:0] snap;
    logic [3:0]    page;
    logic [N-1:0]  chg;
    logic          frz;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          vsync_start = 1'b0;
  logic [BW-1:0] registers;
  logic          freeze_btn = 1'b0;
  logic          page_btn = 1'b0;
  logic [BW-1:0] snapshot;
  logic [3:0]    page_base;
  logic [N-1:0]  changed;
  logic          frozen;

  logic [W-1:0]  r [N];
  logic [BW-1:0] held;
  logic [BW-1:0] all_ones;
  logic          vs_d = 1'b0;
  exp_t          q[$];
  int            checks = 0;
  int            errors = 0;

  register_view_scheduler #(
    .NUM_REGS        (N),
    .REG_W           (W),
    .PAGE_SIZE       (4),
    .DEBOUNCE_CYCLES (4),
    .HILITE_FRAMES   (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .vsync_start (vsync_start),
    .registers   (registers),
    .freeze_btn  (freeze_btn),
    .page_btn    (page_btn),
    .snapshot    (snapshot),
    .page_base   (page_base),
    .changed     (changed),
    .frozen      (frozen)
  );

  always #5 clk = ~clk;

  function automatic logic [BW-1:0] pack();
    logic [BW-1:0] v;
    for (int i = 0; i < N; i++) v[(N-1-i)*W +: W] = r[i];
    return v;
  endfunction

  always_comb registers = pack();

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Outputs update on the vsync edge; compare on the following falling edge.
  always @(posedge clk) vs_d <= vsync_start;

  always @(negedge clk) begin
    if (!rst && vs_d) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame actual=frame required=none");
      end else begin
        exp_t e;
        e = q.pop_front();
        check("frame_snapshot", snapshot, e.snap);
        check("frame_page_base", BW'(page_base), BW'(e.page));
        check("frame_changed", BW'(changed), BW'(e.chg));
        check("frame_frozen", BW'(frozen), BW'(e.frz));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frame(input logic [BW-1:0] snap, input logic [3:0] page,
                       input logic [N-1:0] chg, input logic frz);
    exp_t e;
    e.snap = snap; e.page = page; e.chg = chg; e.frz = frz;
    q.push_back(e);
    vsync_start = 1'b1;
    tick(1);
    vsync_start = 1'b0;
    tick(3);
  endtask

  task automatic press_page();
    page_btn = 1'b1; tick(12);
    page_btn = 1'b0; tick(12);
  endtask

  task automatic press_freeze();
    freeze_btn = 1'b1; tick(12);
    freeze_btn = 1'b0; tick(12);
  endtask

  initial begin
    for (int i = 0; i < N; i++) r[i] = 16'hFFFF;
    all_ones = '1;
    // Reset held with a live bus and a vsync pulse: nothing may be captured.
    tick(2);
    vsync_start = 1'b1; tick(1); vsync_start = 1'b0; tick(1);
    check("reset_snapshot", snapshot, '0);
    check("reset_page_base", BW'(page_base), '0);
    check("reset_changed", BW'(changed), '0);
    check("reset_frozen", BW'(frozen), '0);
    rst = 1'b0;
    tick(3);

    // First capture: every word differs from the cleared snapshot.
    frame(all_ones, 4'd0, 11'h7FF, 1'b0);
    for (int i = 0; i < N; i++) r[i] = 16'h1000 + 16'(i);
    frame(pack(), 4'd0, 11'h7FF, 1'b0);
    frame(pack(), 4'd0, 11'h7FF, 1'b0);
    frame(pack(), 4'd0, 11'h7FF, 1'b0);
    frame(pack(), 4'd0, 11'h000, 1'b0);

    // Tear check: bus change between pulses must not reach the snapshot.
    held = pack();
    r[1] = 16'h1234;
    tick(5);
    check("hold_between_pulses", snapshot, held);
    frame(pack(), 4'd0, 11'h002, 1'b0);
    frame(pack(), 4'd0, 11'h002, 1'b0);
    frame(pack(), 4'd0, 11'h002, 1'b0);
    frame(pack(), 4'd0, 11'h000, 1'b0);

    // Page wrap 4, 8, 0, 4 with one press per frame.
    press_page();
    check("page_hold_until_vsync", BW'(page_base), BW'(4'd0));
    frame(pack(), 4'd4, 11'h000, 1'b0);
    press_page(); frame(pack(), 4'd8, 11'h000, 1'b0);
    press_page(); frame(pack(), 4'd0, 11'h000, 1'b0);
    press_page(); frame(pack(), 4'd4, 11'h000, 1'b0);

    // A 2-cycle bounce is rejected; two presses in a frame collapse to one.
    page_btn = 1'b1; tick(2); page_btn = 1'b0; tick(12);
    frame(pack(), 4'd4, 11'h000, 1'b0);
    press_page(); press_page();
    frame(pack(), 4'd8, 11'h000, 1'b0);
    press_page(); frame(pack(), 4'd0, 11'h000, 1'b0);

    // Freeze: the freezing frame is still captured, later changes are not.
    r[5] = 16'h5555;
    press_freeze();
    frame(pack(), 4'd0, 11'h020, 1'b1);
    held = pack();
    r[3] = 16'hBEEF;
    frame(held, 4'd0, 11'h020, 1'b1);
    frame(held, 4'd0, 11'h020, 1'b1);
    press_freeze();
    frame(held, 4'd0, 11'h000, 1'b0);
    frame(pack(), 4'd0, 11'h008, 1'b0);

    // Press event lands on the vsync cycle: applied one frame later.
    page_btn = 1'b1;
    tick(6);
    begin
      exp_t e;
      e.snap = pack(); e.page = 4'd0; e.chg = 11'h008; e.frz = 1'b0;
      q.push_back(e);
    end
    vsync_start = 1'b1; tick(1); vsync_start = 1'b0;
    tick(10);
    page_btn = 1'b0; tick(12);
    frame(pack(), 4'd4, 11'h008, 1'b0);
    frame(pack(), 4'd4, 11'h000, 1'b0);

    // Asynchronous reset while a highlight is active.
    r[0] = 16'h0A0A;
    frame(pack(), 4'd4, 11'h001, 1'b0);
    #3 rst = 1'b1;
    #1;
    check("async_reset_changed", BW'(changed), '0);
    check("async_reset_snapshot", snapshot, '0);
    check("async_reset_page_base", BW'(page_base), '0);
    check("async_reset_frozen", BW'(frozen), '0);
    tick(2);

    check("all_frames_seen", BW'(q.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
